// File: rtl/vga_sync_out_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_sync_out_if : upstream pixel stream (valid/ready + sof) bundle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef H_COUNT
`define H_COUNT 800
`endif
`ifndef V_COUNT
`define V_COUNT 525
`endif

interface vga_sync_out_if #(
    parameter int RGB_SIZE = 12
) ();
    logic                src_vld;
    logic                src_sof;
    logic [RGB_SIZE-1:0] src_rgb;
    logic                src_rdy;

    modport master (output src_vld, output src_sof, output src_rgb, input  src_rdy);
    modport slave  (input  src_vld, input  src_sof, input  src_rgb, output src_rdy);
endinterface
`default_nettype wire

// File: rtl/vga_sync_out.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_sync_out : VGA sync generation, pixel pull, pin alignment and   |
// |                underflow / start-of-frame status                    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef H_COUNT
`define H_COUNT 800
`endif
`ifndef V_COUNT
`define V_COUNT 525
`endif

module vga_sync_out #(
    parameter int                  RSIZE        = 4,
    parameter int                  GSIZE        = 4,
    parameter int                  BSIZE        = 4,
    parameter int                  RGB_SIZE     = 12,
    parameter int                  H_SYNC_START = 656,
    parameter int                  H_SYNC_END   = 752,
    parameter int                  V_SYNC_START = 490,
    parameter int                  V_SYNC_END   = 492,
    parameter int                  SYNC_POL     = 0,
    parameter int                  LATENCY      = 2,
    parameter logic [RGB_SIZE-1:0] UF_COLOR     = '0
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [`H_SIZE-1:0]  hcount,
    input  wire logic [`V_SIZE-1:0]  vcount,
    input  wire logic                frame_start,
    input  wire logic                frame_end,
    input  wire logic                frame_display,
    vga_sync_out_if.slave            src,
    input  wire logic                clear_stat,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     vga_de,
    output logic [RSIZE-1:0]         vga_r,
    output logic [GSIZE-1:0]         vga_g,
    output logic [BSIZE-1:0]         vga_b,
    output logic                     underflow,
    output logic                     sof_err,
    output logic [15:0]              uf_frames
);

    localparam int                   c_W        = 3 + RGB_SIZE;
    localparam logic                 c_ACT      = (SYNC_POL != 0);
    localparam logic [c_W-1:0]       c_RST_WORD = {~c_ACT, ~c_ACT, 1'b0, {RGB_SIZE{1'b0}}};
    localparam logic [`H_SIZE-1:0]   c_HS_START = H_SYNC_START[`H_SIZE-1:0];
    localparam logic [`H_SIZE-1:0]   c_HS_END   = H_SYNC_END[`H_SIZE-1:0];
    localparam logic [`V_SIZE-1:0]   c_VS_START = V_SYNC_START[`V_SIZE-1:0];
    localparam logic [`V_SIZE-1:0]   c_VS_END   = V_SYNC_END[`V_SIZE-1:0];

    generate
        if (RGB_SIZE != RSIZE + GSIZE + BSIZE) begin : g_bad_rgb
            $error("vga_sync_out: RGB_SIZE must equal RSIZE+GSIZE+BSIZE");
        end
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("vga_sync_out: LATENCY must be in 1..8");
        end
        if (H_SYNC_END > `H_COUNT || V_SYNC_END > `V_COUNT) begin : g_bad_sync
            $error("vga_sync_out: sync window exceeds frame size");
        end
    endgenerate

    logic                w_hs;
    logic                w_vs;
    logic                w_pop;
    logic                w_uf;
    logic [RGB_SIZE-1:0] w_pix;
    logic [c_W-1:0]      w_last;

    logic [c_W-1:0]      pipe_d [LATENCY];
    logic [c_W-1:0]      pipe_q [LATENCY];
    logic                underflow_d, underflow_q;
    logic                sof_err_d, sof_err_q;
    logic                frame_uf_d, frame_uf_q;
    logic [15:0]         uf_frames_d, uf_frames_q;

    // Ready is purely positional so upstream never sees ready depend on valid.
    assign src.src_rdy = frame_display;
    assign w_pop       = frame_display & src.src_vld;
    assign w_uf        = frame_display & ~src.src_vld;

    always_comb begin
        w_hs = ~c_ACT;
        w_vs = ~c_ACT;
        if (hcount >= c_HS_START && hcount < c_HS_END) w_hs = c_ACT;
        if (vcount >= c_VS_START && vcount < c_VS_END) w_vs = c_ACT;
        w_pix = '0;
        if (w_pop)     w_pix = src.src_rgb;
        else if (w_uf) w_pix = UF_COLOR;
    end

    always_comb begin
        pipe_d[0] = {w_hs, w_vs, frame_display, w_pix};
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= c_RST_WORD;
        end else begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    // Clear wins over any same-cycle set; an underflow on frame_end counts in that frame.
    always_comb begin
        underflow_d = underflow_q | w_uf;
        sof_err_d   = sof_err_q | (w_pop & (src.src_sof != frame_start));
        frame_uf_d  = frame_end ? 1'b0 : (frame_uf_q | w_uf);
        uf_frames_d = uf_frames_q;
        if (frame_end && (frame_uf_q || w_uf) && uf_frames_q != 16'hFFFF) begin
            uf_frames_d = uf_frames_q + 16'd1;
        end
        if (clear_stat) begin
            underflow_d = 1'b0;
            sof_err_d   = 1'b0;
            frame_uf_d  = 1'b0;
            uf_frames_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
            sof_err_q   <= 1'b0;
            frame_uf_q  <= 1'b0;
            uf_frames_q <= 16'd0;
        end else begin
            underflow_q <= underflow_d;
            sof_err_q   <= sof_err_d;
            frame_uf_q  <= frame_uf_d;
            uf_frames_q <= uf_frames_d;
        end
    end

    assign w_last    = pipe_q[LATENCY-1];
    assign vga_hsync = w_last[c_W-1];
    assign vga_vsync = w_last[c_W-2];
    assign vga_de    = w_last[c_W-3];
    assign vga_r     = w_last[RGB_SIZE-1 -: RSIZE];
    assign vga_g     = w_last[BSIZE +: GSIZE];
    assign vga_b     = w_last[0 +: BSIZE];
    assign underflow = underflow_q;
    assign sof_err   = sof_err_q;
    assign uf_frames = uf_frames_q;

endmodule
`default_nettype wire
